// File: rtl/des_search_pkg.sv
// Shared state encoding and index-to-key expansion for the DES key-search controller.
package des_search_pkg;

    localparam int KEY_W     = 64;
    localparam int MAX_IDX_W = 56;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FOUND,
        ST_EXHAUSTED
    } state_e;

    // Each key byte is seven index bits above an odd-parity bit in the LSB.
    function automatic logic [KEY_W-1:0] expand_key(input logic [MAX_IDX_W-1:0] idx);
        logic [KEY_W-1:0] key;
        key = '0;
        for (int b = 0; b < 8; b++) begin
            key[8*b+1 +: 7] = idx[7*b +: 7];
            key[8*b]        = ~(^idx[7*b +: 7]);
        end
        return key;
    endfunction

endpackage

// File: rtl/des_search_delay.sv
// Fixed-depth tag/valid shift register that pairs engine results with the keys that produced them.
module des_search_delay #(
    parameter int LAT   = 16,
    parameter int TAG_W = 56,
    parameter int VLD_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [VLD_W-1:0] in_vld,
    output logic [TAG_W-1:0] out_tag,
    output logic [VLD_W-1:0] out_vld,
    output logic             pending
);

    logic [TAG_W-1:0] tag_q [LAT];
    logic [TAG_W-1:0] tag_d [LAT];
    logic [VLD_W-1:0] vld_q [LAT];
    logic [VLD_W-1:0] vld_d [LAT];

    always_comb begin
        tag_d[0] = in_tag;
        vld_d[0] = flush ? '0 : in_vld;
        for (int k = 1; k < LAT; k++) begin
            tag_d[k] = tag_q[k-1];
            vld_d[k] = flush ? '0 : vld_q[k-1];
        end
        // Anything still upstream of the output stage is not yet checked.
        pending = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            pending = pending | (|vld_q[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
                vld_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= tag_d[k];
                vld_q[k] <= vld_d[k];
            end
        end
    end

    assign out_tag = tag_q[LAT-1];
    assign out_vld = vld_q[LAT-1];

endmodule

// File: rtl/des_key_search_ctrl.sv
// Range-bounded up/down candidate-key sequencer and first-match checker for LANES parallel DES engines.
module des_key_search_ctrl
    import des_search_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LAT   = 16,
    parameter int IDX_W = 56
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mode_down,
    input  logic [IDX_W-1:0]       range_lo,
    input  logic [IDX_W-1:0]       range_hi,
    input  logic [KEY_W-1:0]       ciphertext,
    output logic [LANES*KEY_W-1:0] eng_key,
    output logic [LANES-1:0]       eng_valid,
    input  logic [LANES*KEY_W-1:0] eng_ct,
    output logic                   busy,
    output logic                   key_found,
    output logic                   exhausted,
    output logic                   range_err,
    output logic [KEY_W-1:0]       Key,
    output logic [IDX_W-1:0]       count
);

    localparam int EW = IDX_W + 1;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       cur_q, cur_d, lo_q, lo_d, hi_q, hi_d, base_q, base_d;
    logic                   down_q, down_d;
    logic [KEY_W-1:0]       ct_q, ct_d, key_q, key_d;
    logic [LANES*KEY_W-1:0] eng_key_q, eng_key_d;
    logic [LANES-1:0]       eng_valid_q, eng_valid_d;
    logic                   busy_q, busy_d, found_q, found_d, exh_q, exh_d, rerr_q, rerr_d;
    logic [IDX_W-1:0]       count_q, count_d;

    logic [LANES-1:0]       lane_ok;
    logic [LANES*KEY_W-1:0] lane_key;
    logic [EW-1:0]          lane_ext;
    logic                   last_grp;
    logic [IDX_W-1:0]       dl_base, win_off, win_idx, inc;
    logic [LANES-1:0]       dl_vld;
    logic                   dl_pending, hit_any, flush;

    des_search_delay #(.LAT(LAT), .TAG_W(IDX_W), .VLD_W(LANES)) u_delay (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .in_tag  (base_q),
        .in_vld  (eng_valid_q),
        .out_tag (dl_base),
        .out_vld (dl_vld),
        .pending (dl_pending)
    );

    // Widened arithmetic so range checks never wrap past 0 or the top of the index space.
    always_comb begin
        lane_ok  = '0;
        lane_key = '0;
        lane_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            if (down_q) begin
                lane_ext   = {1'b0, cur_q} - EW'(i);
                lane_ok[i] = !lane_ext[IDX_W] && (lane_ext[IDX_W-1:0] >= lo_q);
            end else begin
                lane_ext   = {1'b0, cur_q} + EW'(i);
                lane_ok[i] = (lane_ext <= {1'b0, hi_q});
            end
            lane_key[KEY_W*i +: KEY_W] = expand_key(MAX_IDX_W'(lane_ext[IDX_W-1:0]));
        end
        if (down_q) begin
            lane_ext = {1'b0, cur_q} - EW'(LANES - 1);
            last_grp = lane_ext[IDX_W] || (lane_ext[IDX_W-1:0] <= lo_q);
        end else begin
            lane_ext = {1'b0, cur_q} + EW'(LANES - 1);
            last_grp = (lane_ext >= {1'b0, hi_q});
        end
    end

    // Lowest matching lane wins; lanes after it are neither counted nor reported.
    always_comb begin
        hit_any = 1'b0;
        win_off = '0;
        inc     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!hit_any && dl_vld[i]) begin
                inc = inc + IDX_W'(1);
                if (eng_ct[KEY_W*i +: KEY_W] == ct_q) begin
                    hit_any = 1'b1;
                    win_off = IDX_W'(i);
                end
            end
        end
        win_idx = down_q ? (dl_base - win_off) : (dl_base + win_off);
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        base_d      = base_q;
        down_d      = down_q;
        ct_d        = ct_q;
        key_d       = key_q;
        eng_key_d   = eng_key_q;
        eng_valid_d = '0;
        busy_d      = busy_q;
        found_d     = found_q;
        exh_d       = exh_q;
        rerr_d      = rerr_q;
        count_d     = count_q;
        flush       = 1'b0;
        case (state_q)
            ST_ISSUE, ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    flush   = 1'b1;
                end else if (hit_any) begin
                    count_d = count_q + inc;
                    key_d   = expand_key(MAX_IDX_W'(win_idx));
                    found_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_FOUND;
                    flush   = 1'b1;
                end else begin
                    count_d = count_q + inc;
                    if (state_q == ST_ISSUE) begin
                        eng_valid_d = lane_ok;
                        eng_key_d   = lane_key;
                        base_d      = cur_q;
                        if (last_grp) begin
                            state_d = ST_DRAIN;
                        end else begin
                            cur_d = down_q ? (cur_q - IDX_W'(LANES)) : (cur_q + IDX_W'(LANES));
                        end
                    end else if (!dl_pending && (eng_valid_q == '0)) begin
                        state_d = ST_EXHAUSTED;
                        exh_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                if (start && !abort) begin
                    found_d = 1'b0;
                    exh_d   = 1'b0;
                    if (range_lo > range_hi) begin
                        rerr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rerr_d  = 1'b0;
                        count_d = '0;
                        lo_d    = range_lo;
                        hi_d    = range_hi;
                        down_d  = mode_down;
                        ct_d    = ciphertext;
                        cur_d   = mode_down ? range_hi : range_lo;
                        busy_d  = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            base_q      <= '0;
            down_q      <= 1'b0;
            ct_q        <= '0;
            key_q       <= '0;
            eng_key_q   <= '0;
            eng_valid_q <= '0;
            busy_q      <= 1'b0;
            found_q     <= 1'b0;
            exh_q       <= 1'b0;
            rerr_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            base_q      <= base_d;
            down_q      <= down_d;
            ct_q        <= ct_d;
            key_q       <= key_d;
            eng_key_q   <= eng_key_d;
            eng_valid_q <= eng_valid_d;
            busy_q      <= busy_d;
            found_q     <= found_d;
            exh_q       <= exh_d;
            rerr_q      <= rerr_d;
            count_q     <= count_d;
        end
    end

    assign eng_key   = eng_key_q;
    assign eng_valid = eng_valid_q;
    assign busy      = busy_q;
    assign key_found = found_q;
    assign exhausted = exh_q;
    assign range_err = rerr_q;
    assign Key       = key_q;
    assign count     = count_q;

endmodule

// File: tb/tb_des_key_search_ctrl.sv
// Directed bench for des_key_search_ctrl with a behavioural fixed-latency engine model.
module tb_des_key_search_ctrl;

    localparam int LANES = 4;
    localparam int LAT   = 16;
    localparam int IDX_W = 56;
    localparam logic [63:0] TGT = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] K25 = 64'h010101010101014a;
    localparam logic [63:0] K11 = 64'h0101010101010123;
    localparam logic [63:0] K13 = 64'h0101010101010126;
    localparam logic [63:0] K80 = 64'h0101010101010201;
    localparam logic [63:0] K01 = 64'h0101010101010102;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start, abort, mode_down;
    logic [IDX_W-1:0]       range_lo, range_hi;
    logic [63:0]            ciphertext;
    logic [LANES*64-1:0]    eng_key;
    logic [LANES-1:0]       eng_valid;
    logic [LANES*64-1:0]    eng_ct;
    logic                   busy, key_found, exhausted, range_err;
    logic [63:0]            Key;
    logic [IDX_W-1:0]       count;

    logic [63:0]            match_a, match_b;
    logic [LANES*64-1:0]    pipe [LAT];
    int                     cyc = 0;
    int                     nvec = 0;
    int                     nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    des_key_search_ctrl #(.LANES(LANES), .LAT(LAT), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mode_down  (mode_down),
        .range_lo   (range_lo),
        .range_hi   (range_hi),
        .ciphertext (ciphertext),
        .eng_key    (eng_key),
        .eng_valid  (eng_valid),
        .eng_ct     (eng_ct),
        .busy       (busy),
        .key_found  (key_found),
        .exhausted  (exhausted),
        .range_err  (range_err),
        .Key        (Key),
        .count      (count)
    );

    function automatic logic [LANES*64-1:0] engine_resp(input logic [LANES*64-1:0] keys,
                                                         input logic [63:0] a, input logic [63:0] b);
        logic [LANES*64-1:0] r;
        logic [63:0]         k;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            k = keys[64*i +: 64];
            r[64*i +: 64] = (k == a || k == b) ? TGT : ~k;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= engine_resp(eng_key, match_a, match_b);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign eng_ct = pipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_eng_valid"}, 64'(eng_valid), 64'd0);
        chk({tag, "_eng_key_or"}, 64'(|eng_key), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_key_found"}, 64'(key_found), 64'd0);
        chk({tag, "_exhausted"}, 64'(exhausted), 64'd0);
        chk({tag, "_range_err"}, 64'(range_err), 64'd0);
        chk({tag, "_Key"}, Key, 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
    endtask

    typedef struct {
        logic        down;
        logic [55:0] lo;
        logic [55:0] hi;
        logic [63:0] ma;
        logic [63:0] mb;
        logic        found;
        logic        exh;
        logic        rerr;
        logic [63:0] key;
        int          cnt;
        int          lat;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v, input int n);
        int   t0, tf;
        logic busy_at_found;
        logic [3:0] last_mask;
        logic done;
        @(negedge clk);
        mode_down  = v.down;
        range_lo   = v.lo;
        range_hi   = v.hi;
        ciphertext = TGT;
        match_a    = v.ma;
        match_b    = v.mb;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = -1; tf = -1; busy_at_found = 1'b1; last_mask = '0; done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (eng_valid != '0) begin
                if (t0 < 0) t0 = cyc;
                last_mask = eng_valid;
            end
            if (key_found && tf < 0) begin
                tf = cyc;
                busy_at_found = busy;
            end
            if (!busy && (key_found || exhausted || range_err)) done = 1'b1;
            else @(negedge clk);
        end
        chk($sformatf("v%0d_done", n), 64'(done), 64'd1);
        chk($sformatf("v%0d_key_found", n), 64'(key_found), 64'(v.found));
        chk($sformatf("v%0d_exhausted", n), 64'(exhausted), 64'(v.exh));
        chk($sformatf("v%0d_range_err", n), 64'(range_err), 64'(v.rerr));
        chk($sformatf("v%0d_last_mask", n), 64'(last_mask), 64'(v.mask));
        chk($sformatf("v%0d_busy", n), 64'(busy), 64'd0);
        if (v.found) begin
            chk($sformatf("v%0d_Key", n), Key, v.key);
            chk($sformatf("v%0d_busy_at_found", n), 64'(busy_at_found), 64'd0);
        end
        if (v.cnt >= 0) chk($sformatf("v%0d_count", n), 64'(count), 64'(v.cnt));
        if (v.lat > 0) chk($sformatf("v%0d_latency", n), 64'(tf - t0), 64'(v.lat));
    endtask

    initial begin
        logic seen;
        vecs[0] = '{1'b0, 56'h0,  56'hFF, K25, 64'h0, 1'b1, 1'b0, 1'b0, K25,   38, 26, 4'hF};
        vecs[1] = '{1'b1, 56'h20, 56'h27, K25, 64'h0, 1'b1, 1'b0, 1'b0, K25,    3, 17, 4'hF};
        vecs[2] = '{1'b0, 56'h0,  56'h9,  K25, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 10,  0, 4'b0011};
        vecs[3] = '{1'b1, 56'h0,  56'h5,  K25, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0,  6,  0, 4'b0011};
        vecs[4] = '{1'b0, 56'h10, 56'h1F, K11, K13,   1'b1, 1'b0, 1'b0, K11,    2, 17, 4'hF};
        vecs[5] = '{1'b0, 56'h5,  56'h4,  K25, 64'h0, 1'b0, 1'b0, 1'b1, 64'h0, -1,  0, 4'h0};
        vecs[6] = '{1'b0, 56'h25, 56'h25, K25, 64'h0, 1'b1, 1'b0, 1'b0, K25,    1, 17, 4'b0001};
        vecs[7] = '{1'b1, 56'h7E, 56'h81, K80, 64'h0, 1'b1, 1'b0, 1'b0, K80,    2, 17, 4'hF};

        reset = 1'b0; start = 1'b0; abort = 1'b0; mode_down = 1'b0;
        range_lo = '0; range_hi = '0; ciphertext = '0; match_a = '0; match_b = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        // start and abort together while idle: nothing may start
        @(negedge clk);
        range_lo = 56'h0; range_hi = 56'hFF; ciphertext = TGT; match_a = K01;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (busy || eng_valid != '0 || key_found) seen = 1'b1;
            @(negedge clk);
        end
        chk("start_abort_idle_activity", 64'(seen), 64'd0);

        for (int n = 0; n < 8; n++) run_vec(vecs[n], n);

        // abort three cycles into ISSUE with a matching key already in flight
        @(negedge clk);
        mode_down = 1'b0; range_lo = 56'h0; range_hi = 56'hFF; ciphertext = TGT;
        match_a = K01; match_b = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_eng_valid", 64'(eng_valid), 64'd0);
        chk("abort_count", 64'(count), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < LAT + 6; c++) begin
            if (busy || key_found || exhausted || range_err || eng_valid != '0) seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_flags", 64'(seen), 64'd0);

        // reset asserted while draining
        match_a = '0;
        range_lo = 56'h0; range_hi = 56'h9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_eng_valid", 64'(eng_valid), 64'd0);
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < LAT + 6; c++) begin
            if (busy || key_found || exhausted || eng_valid != '0) seen = 1'b1;
            @(negedge clk);
        end
        chk("postreset_quiet", 64'(seen), 64'd0);
        chk_all_zero("postreset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/des_key_search_ctrl.md
Name: des_key_search_ctrl

Overview:
- Parametrised candidate-key sequencer and result checker for the DES brute-force search top level.
- Each cycle it issues up to LANES candidate keys, one per lane, to LANES fixed-latency DES encrypt engines that sit outside this block.
- It compares each returned ciphertext against the target and reports the first matching key in search order.
- It adds range-bounded, up/down searching and abort over the earlier single-counter controller.

Parameters:
- LANES, 4, number of parallel DES engines (1..16).
- LAT, 16, fixed engine latency in cycles from key issue to ciphertext return (>=1).
- IDX_W, 56, search index width; key entropy bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a search when idle, ignored when busy.
- abort  in  1  pulse; cancels the search in progress.
- mode_down  in  1  0 = search range_lo up to range_hi; 1 = range_hi down to range_lo. Sampled on start.
- range_lo  in  IDX_W  inclusive lower bound, sampled on start.
- range_hi  in  IDX_W  inclusive upper bound, sampled on start.
- ciphertext  in  64  target ciphertext, sampled on start.
- eng_key  out  LANES*64  candidate keys; lane i occupies bits [64i+63:64i].
- eng_valid  out  LANES  per-lane issue strobe.
- eng_ct  in  LANES*64  engine results, aligned LAT cycles after the matching issue.
- busy  out  1  search in progress, including the drain phase.
- key_found  out  1  sticky until the next start or reset.
- exhausted  out  1  sticky; the whole range was tested with no match.
- range_err  out  1  sticky; start was seen with range_lo > range_hi.
- Key  out  64  matching key with parity applied, valid when key_found.
- count  out  IDX_W  number of candidates checked, including the match.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, delay line cleared.
- Key expansion, index to 64-bit key:
  - Byte b (b = 0 is the LSB) = {idx[7b+6:7b], p}.
  - p is odd parity over those 7 bits.
  - Example: idx 0x25 expands to 64'h010101010101014a.
- FSM states: IDLE, ISSUE, DRAIN, FOUND, EXHAUSTED.
- IDLE, start accepted:
  - If range_lo > range_hi: set range_err and stay in IDLE.
  - Otherwise: clear the sticky flags, set count = 0, load cur = range_lo (up) or range_hi (down), go to ISSUE, set busy = 1.
- ISSUE:
  - Lane i gets cur + i (up) or cur - i (down).
  - A lane's eng_valid is 1 only if its index lies within the range.
  - cur advances by LANES each cycle.
  - The last group may be partial. There is no wrap past 0 or 2^IDX_W - 1, and no arithmetic overflow.
  - After the group containing the range end, go to DRAIN.
- Delay line: an LAT-deep shift register carrying {base index, lane valid mask}. It is the authoritative record of which result belongs to which key.
- Checking, every cycle in ISSUE and DRAIN:
  - For each returned lane with its delayed valid bit set, compare eng_ct to the latched ciphertext.
  - Winner is the lowest-index matching lane (earliest in search order).
  - count adds the number of valid lanes checked, truncated at the winner and including it.
- On a match: the next cycle Key is registered, key_found = 1, issuing stops, state = FOUND, busy = 0. Any in-flight results are discarded.
- DRAIN: once the last delayed valid has been checked with no match, go to EXHAUSTED, set exhausted = 1, busy = 0.
- FOUND and EXHAUSTED: hold the outputs; start restarts the search and clears the flags.
- abort in ISSUE or DRAIN:
  - Next state is IDLE, busy = 0, delay line flushed, no flag set.
  - count holds its value.
  - Abort has priority over a match in the same cycle.
- Simultaneous start and abort while idle: abort wins, no search starts.
- Reset mid-search: immediate return to the reset state.
- Latency: with first issue at cycle t0, the result for group g is checked at t0 + g + LAT, and key_found rises at t0 + g + LAT + 1.

Decomposition:
- Package des_search_pkg:
  - FSM state enum.
  - KEY_W = 64.
  - Function expand_key(idx) to 64-bit with odd parity.
- Sub-module des_search_delay: parametrised (LAT, width) valid/tag shift register with synchronous flush.

Test Plan:
- up, range 0..0xFF, LANES 4, LAT 16, behavioural engine matching only key 010101010101014a (idx 0x25) -> key_found 1 at t0 + 9 + 16 + 1, Key = 64'h010101010101014a, count = 38, busy falls the same cycle.
- down, range 0x20..0x27, match at idx 0x25 -> lane 2 of group 0 wins, count = 3.
- up, range 0..9, no match -> last group has eng_valid = 4'b0011, exhausted 1, count = 10, key_found 0.
- Matches injected on lanes 1 and 3 of the same group -> the lane-1 key is reported.
- range_lo = 5, range_hi = 4 -> range_err 1, busy 0, eng_valid never asserts. Then range_lo = range_hi = 0x25 -> single candidate, found with count = 1.
- Abort 3 cycles into ISSUE, then reset deasserted/asserted mid-DRAIN -> after abort busy 0 and no flags; after reset every output is 0.
